ma_nibble_seq: RTL and testbench



---
 rtl/ma_nibble_seq.sv | 158 +++++++++++++++
 tb/tb_ma_nibble_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ma_nibble_seq.sv
// ma_nibble_seq
// -------------
// Sequencing controller for a WIDTH-bit unsigned add (WIDTH = 4*NIBBLES).
// It uses one shared external 4-bit ripple-carry adder slice and feeds it one
// nibble per clock, starting with the least significant nibble. This block
// holds the carry between nibbles and assembles the result. The slice itself
// stays purely combinational.
//
// Optional feature: define MA_NIBBLE_SEQ_OVF_EN to add the 'ovf' output.
// 'ovf' reports two's-complement overflow of the full-width add.
//
// Ports:
//   clk, rst           rising-edge clock; asynchronous active-high reset
//   start_valid/ready  command handshake; a, b and cin are sampled on it
//   a, b, cin          operands and carry-in (WIDTH, WIDTH, 1)
//   slice_a/b/cin      nibble operands and carry driven to the adder slice
//   slice_s/cout       combinational sum and carry returned by the slice
//   done_valid/ready   result handshake
//   sum, cout          result and final carry-out, held until consumed
//   ovf                (MA_NIBBLE_SEQ_OVF_EN only) signed overflow flag
module ma_nibble_seq #(
  parameter int NIBBLES = 4,
  localparam int WIDTH = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_s,
  input  logic             slice_cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef MA_NIBBLE_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic            last_nibble;

  assign last_nibble = (idx == IW'(NIBBLES - 1));

  // State register for the IDLE -> RUN -> DONE sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode. The slice is only driven while RUN is
  // active. At all other times it sees zeros, so its outputs have no meaning.
  always_comb begin
    next_state  = state;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    slice_a     = 4'h0;
    slice_b     = 4'h0;
    slice_cin   = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          next_state = RUN;
        end
      end
      RUN: begin
        slice_a   = a_reg[4*idx +: 4];
        slice_b   = b_reg[4*idx +: 4];
        slice_cin = carry;
        if (last_nibble) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath. Operands are captured on the command handshake. Each RUN edge
  // writes one sum nibble and moves the slice carry into the carry register.
  // On the last nibble, that carry also becomes cout. In DONE the result is
  // simply held: nothing here updates outside IDLE-accept and RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef MA_NIBBLE_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= slice_s;
          carry           <= slice_cout;
          if (last_nibble) begin
            cout <= slice_cout;
`ifdef MA_NIBBLE_SEQ_OVF_EN
            // Overflow occurs when both operands have the same sign and
            // the result's sign bit (the top bit of the last nibble)
            // differs from it.
            ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                    (slice_s[3] != a_reg[WIDTH-1]);
`endif
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ma_nibble_seq.sv
// tb_ma_nibble_seq
// ----------------
// Directed testbench for ma_nibble_seq with NIBBLES=4. It includes a behavioral
// model of the external 4-bit adder slice. Expected results are hand-computed
// constants. If MA_NIBBLE_SEQ_OVF_EN is defined, the overflow cases also run.
module tb_ma_nibble_seq;

  localparam int NIBBLES = 4;
  localparam int WIDTH   = 4 * NIBBLES;

  logic             clk;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic             slice_cin;
  logic [3:0]       slice_s;
  logic             slice_cout;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef MA_NIBBLE_SEQ_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic cinTrace [0:3];

  ma_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .slice_a     (slice_a),
    .slice_b     (slice_b),
    .slice_cin   (slice_cin),
    .slice_s     (slice_s),
    .slice_cout  (slice_cout),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .sum         (sum),
    .cout        (cout)
`ifdef MA_NIBBLE_SEQ_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  // Model of the external combinational 4-bit ripple-carry slice.
  assign {slice_cout, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {4'h0, slice_cin};

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports it if it fails.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one command while the DUT is idle, then steps through the RUN
  // cycles. It records slice_cin on each cycle and checks that done_valid
  // rises exactly NIBBLES edges after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic cv, input string tag);
    checkOutput({tag, "_ready_before"}, 32'(start_ready), 32'd1);
    a           = av;
    b           = bv;
    cin         = cv;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    for (int i = 0; i < NIBBLES; i++) begin
      cinTrace[i] = slice_cin;
      checkOutput({tag, "_busy"}, 32'({done_valid, start_ready}), 32'd0);
      @(posedge clk); #1;
    end
    checkOutput({tag, "_latency"}, 32'(done_valid), 32'd1);
  endtask

  // Consumes the result. The DUT should be idle again on the next cycle.
  task automatic consume(input string tag);
    done_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, "_idle_again"}, 32'({start_ready, done_valid}), 32'b10);
  endtask

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    done_ready  = 1'b1;
    a           = '0;
    b           = '0;
    cin         = 1'b0;

    // Values held during reset.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_start_ready", 32'(start_ready), 32'd1);
    checkOutput("rst_done_valid", 32'(done_valid), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'h0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    checkOutput("rst_slice", 32'({slice_a, slice_b, slice_cin}), 32'h0);
`ifdef MA_NIBBLE_SEQ_OVF_EN
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic add: no carries between nibbles.
    applyStimulus(16'h1234, 16'h4321, 1'b0, "basic");
    checkOutput("basic_sum", 32'(sum), 32'h5555);
    checkOutput("basic_cout", 32'(cout), 32'd0);
    checkOutput("basic_cin_trace", 32'({cinTrace[0], cinTrace[1], cinTrace[2], cinTrace[3]}), 32'b0000);
    consume("basic");

    // Carry ripples through every nibble boundary.
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, "ripple");
    checkOutput("ripple_sum", 32'(sum), 32'h0000);
    checkOutput("ripple_cout", 32'(cout), 32'd1);
    checkOutput("ripple_cin_trace", 32'({cinTrace[0], cinTrace[1], cinTrace[2], cinTrace[3]}), 32'b0111);
    consume("ripple");

    // Carry-in alone wraps the full operand.
    applyStimulus(16'hFFFF, 16'h0000, 1'b1, "cin_wrap");
    checkOutput("cin_wrap_sum", 32'(sum), 32'h0000);
    checkOutput("cin_wrap_cout", 32'(cout), 32'd1);
    checkOutput("cin_wrap_cin_trace", 32'({cinTrace[0], cinTrace[1], cinTrace[2], cinTrace[3]}), 32'b1111);
    consume("cin_wrap");

    // Carry generated only in the top nibble.
    applyStimulus(16'h8000, 16'h8000, 1'b0, "msb");
    checkOutput("msb_sum", 32'(sum), 32'h0000);
    checkOutput("msb_cout", 32'(cout), 32'd1);
    consume("msb");

    // Backpressure: the result is held while done_ready is low. A competing
    // command must not be accepted while it is held.
    done_ready = 1'b0;
    applyStimulus(16'h00F0, 16'h0F10, 1'b0, "bp");
    a           = 16'h0001;
    b           = 16'h0001;
    start_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_hold_sum", 32'(sum), 32'h1000);
      checkOutput("bp_hold_flags", 32'({cout, done_valid, start_ready}), 32'b010);
      @(posedge clk); #1;
    end
    start_valid = 1'b0;
    consume("bp");
    checkOutput("bp_sum_after", 32'(sum), 32'h1000);

    // Reset while idx=2. Everything returns to reset values at once.
    a           = 16'h1234;
    b           = 16'h4321;
    cin         = 1'b0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midrst_pre_slice", 32'({slice_a, slice_b}), 32'h23);
    rst = 1'b1;
    #1;
    checkOutput("midrst_flags", 32'({start_ready, done_valid}), 32'b10);
    checkOutput("midrst_sum", 32'(sum), 32'h0);
    checkOutput("midrst_cout", 32'(cout), 32'd0);
    checkOutput("midrst_slice", 32'({slice_a, slice_b, slice_cin}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_no_done", 32'(done_valid), 32'd0);
    applyStimulus(16'h0001, 16'h0001, 1'b0, "post_rst");
    checkOutput("post_rst_sum", 32'(sum), 32'h0002);
    checkOutput("post_rst_cout", 32'(cout), 32'd0);
    consume("post_rst");

`ifdef MA_NIBBLE_SEQ_OVF_EN
    // Signed overflow cases.
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, "ovf_pos");
    checkOutput("ovf_pos_sum", 32'(sum), 32'h8000);
    checkOutput("ovf_pos_flags", 32'({ovf, cout}), 32'b10);
    consume("ovf_pos");

    applyStimulus(16'h8000, 16'hFFFF, 1'b0, "ovf_neg");
    checkOutput("ovf_neg_sum", 32'(sum), 32'h7FFF);
    checkOutput("ovf_neg_flags", 32'({ovf, cout}), 32'b11);
    consume("ovf_neg");

    applyStimulus(16'h0001, 16'hFFFF, 1'b0, "ovf_none");
    checkOutput("ovf_none_sum", 32'(sum), 32'h0000);
    checkOutput("ovf_none_flags", 32'({ovf, cout}), 32'b01);
    consume("ovf_none");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
